// File: rtl/conv_pkg.sv
// Shared types and fixed-point helpers for the CNN row datapath.
// round_sat works on a wide signed container so any block can reuse it.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

  localparam int RS_W = 128;

  // Round half toward +inf, then clamp to a data_w-bit signed range.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     frac_w,
    input int                     data_w
  );
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    one = {{(RS_W-1){1'b0}}, 1'b1};
    r   = acc;
    if (frac_w > 0) begin
      r = r + (one <<< (frac_w - 1));
      r = r >>> frac_w;
    end
    hi = (one <<< (data_w - 1)) - one;
    lo = -(one <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/q_round_sat.sv
// Combinational round + saturate + optional ReLU from an accumulator
// to a Q(DATA_W-FRAC_W).FRAC_W result.
module q_round_sat
  import conv_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic                     relu_i,
  output logic signed [DATA_W-1:0] res_o
);

  if (ACC_W > RS_W) begin : g_bad_acc
    $error("q_round_sat: ACC_W exceeds helper container width");
  end

  logic signed [RS_W-1:0] acc_ext;
  logic signed [RS_W-1:0] sat;

  assign acc_ext = {{(RS_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign sat     = round_sat(acc_ext, FRAC_W, DATA_W);

  always_comb begin
    res_o = sat[DATA_W-1:0];
    if (relu_i && (sat < 0)) begin
      res_o = '0;
    end
  end

endmodule

// File: rtl/row_conv_engine.sv
// 1-D strided convolution over one buffered input row using a single
// time-multiplexed MAC; results leave through a valid/ready port.
module row_conv_engine
  import conv_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int FRAC_W  = 8,
  parameter  int IN_LEN  = 28,
  parameter  int K       = 8,
  parameter  int STRIDE  = 2,
  parameter  int ACC_W   = 40,
  localparam int OUT_LEN = (IN_LEN - K) / STRIDE + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       relu_en,
  input  logic                       kw_en,
  input  logic [$clog2(K)-1:0]       kw_addr,
  input  logic signed [DATA_W-1:0]   kw_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic [$clog2(OUT_LEN)-1:0] out_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int KA_W = $clog2(K);
  localparam int NA_W = $clog2(IN_LEN);
  localparam int OI_W = $clog2(OUT_LEN);

  localparam logic [NA_W-1:0] LAST_N   = NA_W'(IN_LEN - 1);
  localparam logic [KA_W-1:0] LAST_TAP = KA_W'(K - 1);
  localparam logic [OI_W-1:0] LAST_IDX = OI_W'(OUT_LEN - 1);
  localparam logic [NA_W-1:0] STEP     = NA_W'(STRIDE);
  localparam logic [KA_W:0]   K_LIM    = (KA_W + 1)'(K);

  if (K > IN_LEN) begin : g_bad_k
    $error("row_conv_engine: K must not exceed IN_LEN");
  end
  if (((IN_LEN - K) % STRIDE) != 0) begin : g_bad_stride
    $error("row_conv_engine: (IN_LEN-K) must be a multiple of STRIDE");
  end
  if (ACC_W < 2 * DATA_W + $clog2(K)) begin : g_bad_acc
    $error("row_conv_engine: ACC_W too small for K products");
  end

  logic signed [DATA_W-1:0] kern_q    [K];
  logic signed [DATA_W-1:0] row_buf_q [IN_LEN];

  state_t                   state_q;
  logic [NA_W-1:0]          n_q;
  logic [NA_W-1:0]          base_q;
  logic [KA_W-1:0]          tap_q;
  logic [OI_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     relu_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     done_q;

  logic [NA_W-1:0]            rd_addr;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [DATA_W-1:0]   res;

  assign rd_addr = base_q + NA_W'(tap_q);
  assign prod    = row_buf_q[rd_addr] * kern_q[tap_q];
  assign acc_d   = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Rounded on the accumulator's next value so the result is ready the
  // cycle OUT is entered, giving K+1 cycles per output.
  q_round_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .acc_i (acc_d),
    .relu_i(relu_q),
    .res_o (res)
  );

  // Storage arrays carry no reset so they map onto plain memory.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && kw_en && ({1'b0, kw_addr} < K_LIM)) begin
      kern_q[kw_addr] <= kw_data;
    end
    if (state_q == LOAD && in_valid) begin
      row_buf_q[n_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      base_q     <= '0;
      tap_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            relu_q  <= relu_en;
            n_q     <= '0;
            base_q  <= '0;
            idx_q   <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            n_q <= n_q + 1'b1;
            if (n_q == LAST_N) begin
              state_q <= MAC;
              tap_q   <= '0;
              acc_q   <= '0;
            end
          end
        end
        MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + 1'b1;
          if (tap_q == LAST_TAP) begin
            out_data_q <= res;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              base_q  <= base_q + STEP;
              idx_q   <= idx_q + 1'b1;
              tap_q   <= '0;
              acc_q   <= '0;
              state_q <= MAC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_row_conv_engine.sv
// Directed bench for row_conv_engine: stimulus pushes hand-computed results
// into a scoreboard, and a negedge monitor pops them on each output handshake.
module tb_row_conv_engine;

  localparam int IN_LEN  = 28;
  localparam int K       = 8;
  localparam int OUT_LEN = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        kw_en = 1'b0;
  logic [2:0]  kw_addr = '0;
  logic [15:0] kw_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  row_conv_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .relu_en  (relu_en),
    .kw_en    (kw_en),
    .kw_addr  (kw_addr),
    .kw_data  (kw_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  i;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  logic [15:0] row_q [IN_LEN];
  bit          gaps = 1'b0;
  bit          stall_en = 1'b0;
  bit          stall_done = 1'b0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_d = '0;
  logic [3:0]  prev_i = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, hold-stability while stalled, done/busy counts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (out_valid && prev_hold) begin
        chk("hold_data", 32'(out_data), 32'(prev_d));
        chk("hold_idx", 32'(out_idx), 32'(prev_i));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got idx %0d data 0x%04h, expected no output", out_idx, out_data);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(mon_e.d));
          chk("out_idx", 32'(out_idx), 32'(mon_e.i));
          $display("out idx=%0d data=0x%04h (exp idx=%0d data=0x%04h)", out_idx, out_data, mon_e.i, mon_e.d);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = out_data;
      prev_i    = out_idx;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Holds out_ready low for 5 cycles the first time output 3 is presented.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && !stall_done && out_valid && out_idx == 4'd3) begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready  = 1'b1;
        stall_done = 1'b1;
      end
    end
  end

  task automatic kw(input int a, input logic [15:0] d);
    @(posedge clk);
    #1;
    kw_en   = 1'b1;
    kw_addr = a[2:0];
    kw_data = d;
    @(posedge clk);
    #1;
    kw_en = 1'b0;
  endtask

  task automatic set_kernel(input logic [15:0] t0, input logic [15:0] rest);
    for (int k = 0; k < K; k++) kw(k, (k == 0) ? t0 : rest);
  endtask

  task automatic fill_row(input logic [15:0] v);
    for (int i = 0; i < IN_LEN; i++) row_q[i] = v;
  endtask

  task automatic push_all(input logic [15:0] v);
    for (int j = 0; j < OUT_LEN; j++) sb.push_back('{d: v, i: 4'(j)});
  endtask

  task automatic start_row(input bit relu);
    @(posedge clk);
    #1;
    start   = 1'b1;
    relu_en = relu;
    @(posedge clk);
    #1;
    start   = 1'b0;
    relu_en = 1'b0;
  endtask

  task automatic send_row();
    int i = 0;
    int guard = 0;
    bit acc_ok;
    while (i < IN_LEN && guard < 2000) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = row_q[i];
      end
      @(negedge clk);
      acc_ok = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc_ok) i++;
    end
    in_valid = 1'b0;
    chk("samples_accepted", 32'(i), 32'(IN_LEN));
  endtask

  task automatic wait_done(input int d0);
    int g = 0;
    while (done_cnt == d0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_row(input bit relu);
    int d0;
    d0       = done_cnt;
    busy_cnt = 0;
    start_row(relu);
    send_row();
    wait_done(d0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
  endtask

  initial begin
    int d0;
    int g;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Unit values: 8 taps of 1.0 * 1.0 = 8.0 -> 0x0800, 28 + 11*9 busy cycles
    set_kernel(16'h0100, 16'h0100);
    fill_row(16'h0100);
    push_all(16'h0800);
    run_row(1'b0);
    chk("row_cycles", 32'(busy_cnt), 32'd127);

    // Backpressure, input gaps, and start/kw_en pulses that must be ignored
    gaps       = 1'b1;
    stall_en   = 1'b1;
    stall_done = 1'b0;
    push_all(16'h0800);
    fork
      run_row(1'b0);
      begin
        repeat (10) @(posedge clk);
        #1;
        start   = 1'b1;
        kw_en   = 1'b1;
        kw_addr = 3'd0;
        kw_data = 16'h7FFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        kw_en = 1'b0;
      end
    join
    chk("stall_seen", 32'(stall_done), 32'd1);
    gaps     = 1'b0;
    stall_en = 1'b0;

    // Ramp with a single unit tap: out[j] = input[2j] = (2j) << 8
    set_kernel(16'h0100, 16'h0000);
    for (int i = 0; i < IN_LEN; i++) row_q[i] = 16'(i << 8);
    for (int j = 0; j < OUT_LEN; j++) sb.push_back('{d: 16'(j * 512), i: 4'(j)});
    run_row(1'b0);

    // Saturation both ways, then negative with ReLU
    set_kernel(16'h7FFF, 16'h7FFF);
    fill_row(16'h7FFF);
    push_all(16'h7FFF);
    run_row(1'b0);
    fill_row(16'h8000);
    push_all(16'h8000);
    run_row(1'b0);
    push_all(16'h0000);
    run_row(1'b1);

    // Rounding: 0x80 -> 1, 0x180 -> 2, -0x80 -> 0, -0x180 -> -1
    set_kernel(16'h0080, 16'h0000);
    fill_row(16'h0000);
    row_q[0] = 16'h0001;
    row_q[2] = 16'h0003;
    sb.push_back('{d: 16'h0001, i: 4'd0});
    sb.push_back('{d: 16'h0002, i: 4'd1});
    for (int j = 2; j < OUT_LEN; j++) sb.push_back('{d: 16'h0000, i: 4'(j)});
    run_row(1'b0);
    row_q[0] = 16'hFFFF;
    row_q[2] = 16'hFFFD;
    sb.push_back('{d: 16'h0000, i: 4'd0});
    sb.push_back('{d: 16'hFFFF, i: 4'd1});
    for (int j = 2; j < OUT_LEN; j++) sb.push_back('{d: 16'h0000, i: 4'(j)});
    run_row(1'b0);

    // Reset during the MAC of output 5, then a clean row on the kept kernel
    set_kernel(16'h0100, 16'h0100);
    fill_row(16'h0100);
    for (int j = 0; j < 5; j++) sb.push_back('{d: 16'h0800, i: 4'(j)});
    d0 = done_cnt;
    start_row(1'b0);
    send_row();
    found = 1'b0;
    g     = 0;
    while (!found && g < 2000) begin
      @(negedge clk);
      g++;
      if (busy && !out_valid && out_idx == 4'd5) found = 1'b1;
    end
    chk("reached_mac5", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("after_rst");
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_sb", 32'(sb.size()), 32'd0);
    push_all(16'h0800);
    run_row(1'b0);
    chk("row_cycles_again", 32'(busy_cnt), 32'd127);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
